// File: rtl/cmos_capture_pkg.sv
// Shared image-pipeline definitions: frame geometry and capture FSM encoding.
package cmos_capture_pkg;

  localparam int IMG_H_PIXELS = 640;
  localparam int IMG_V_LINES  = 480;

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cmos_capture_if.sv
// DVP camera bus in, RGB565 pixel stream out. master = capture block, slave = sensor/consumer side.
interface cmos_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        frame_err;

  modport master (
    input  cam_vsync, cam_href, cam_data,
    output dout, dout_vld, dout_sop, dout_eop, frame_err
  );
  modport slave (
    output cam_vsync, cam_href, cam_data,
    input  dout, dout_vld, dout_sop, dout_eop, frame_err
  );
endinterface

// File: rtl/dvp_byte_pair.sv
// Pairs registered DVP bytes into RGB565 words; hi byte first, toggle cleared while href is low.
module dvp_byte_pair (
  input  logic        clk,
  input  logic        rst,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic [15:0] pix_o,
  output logic        vld_o
);

  logic       tog_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= 1'b0;
      hi_q  <= 8'h00;
    end else if (!href_i) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= ~tog_q;
      if (!tog_q) hi_q <= data_i;
    end
  end

  // Combinational so the top's output register gives exactly two cycles of latency.
  assign vld_o = href_i & tog_q;
  assign pix_o = {hi_q, data_i};

endmodule

// File: rtl/cmos_capture.sv
// DVP camera capture: skips settling frames, assembles RGB565, tags sop/eop and flags short frames.
module cmos_capture
  import cmos_capture_pkg::*;
#(
  parameter int H_PIXELS    = IMG_H_PIXELS,
  parameter int V_LINES     = IMG_V_LINES,
  parameter int SKIP_FRAMES = 10
) (
  input logic           clk,
  input logic           rst,
  cmos_capture_if.master bus
);

  localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  logic       vs_q, vs_p_q, href_q, href_p_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= 1'b0;
      vs_p_q   <= 1'b0;
      href_q   <= 1'b0;
      href_p_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      vs_q     <= bus.cam_vsync;
      vs_p_q   <= vs_q;
      href_q   <= bus.cam_href;
      href_p_q <= href_q;
      data_q   <= bus.cam_data;
    end
  end

  logic vs_rise, href_fall;
  assign vs_rise   = vs_q & ~vs_p_q;
  assign href_fall = href_p_q & ~href_q;

  logic [15:0] pix;
  logic        pix_vld;

  dvp_byte_pair u_pair (
    .clk    (clk),
    .rst    (rst),
    .href_i (href_q),
    .data_i (data_q),
    .pix_o  (pix),
    .vld_o  (pix_vld)
  );

  cap_state_e    state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic          cap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SKIP;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      ST_SKIP: begin
        if (SKIP_FRAMES == 0) begin
          state_d = ST_WAIT_VS;
        end else if (vs_rise) begin
          // Edge SKIP_FRAMES+1 opens the first frame that is kept.
          if (skip_q == SW'(SKIP_FRAMES)) state_d = ST_CAPTURE;
          else                            skip_d  = skip_q + 1'b1;
        end
      end
      ST_WAIT_VS: if (vs_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_CAPTURE;
      default:    state_d = ST_SKIP;
    endcase
  end

  always_comb begin
    cap_en = (state_q == ST_CAPTURE);
  end

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          cfull_q, cfull_d, over_q, over_d;
  logic          gotp_q, gotp_d, eopd_q, eopd_d;
  logic [15:0]   dout_q, dout_d;
  logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, ferr_q, ferr_d;
  logic          accept, last_col, last_row;

  // cfull/over extend the saturated counters so overflow pixels and rows are dropped.
  assign last_col = (col_q == CW'(H_PIXELS - 1));
  assign last_row = (row_q == RW'(V_LINES - 1));
  assign accept   = cap_en & pix_vld & ~vs_rise & ~cfull_q & ~over_q;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    cfull_d = cfull_q;
    over_d  = over_q;
    gotp_d  = gotp_q;
    eopd_d  = eopd_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    ferr_d  = 1'b0;
    if (vs_rise) begin
      ferr_d  = cap_en & gotp_q & ~eopd_q;
      col_d   = '0;
      row_d   = '0;
      cfull_d = 1'b0;
      over_d  = 1'b0;
      gotp_d  = 1'b0;
      eopd_d  = 1'b0;
    end else begin
      if (accept) begin
        dout_d = pix;
        vld_d  = 1'b1;
        sop_d  = (col_q == '0) && (row_q == '0);
        eop_d  = last_col && last_row;
        gotp_d = 1'b1;
        if (last_col && last_row) eopd_d = 1'b1;
        if (last_col) cfull_d = 1'b1;
        else          col_d   = col_q + 1'b1;
      end
      if (href_fall && (col_q != '0 || cfull_q)) begin
        col_d   = '0;
        cfull_d = 1'b0;
        if (last_row) over_d = 1'b1;
        else          row_d  = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      cfull_q <= 1'b0;
      over_q  <= 1'b0;
      gotp_q  <= 1'b0;
      eopd_q  <= 1'b0;
      dout_q  <= 16'h0000;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cfull_q <= cfull_d;
      over_q  <= over_d;
      gotp_q  <= gotp_d;
      eopd_q  <= eopd_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.dout_sop  = sop_q;
  assign bus.dout_eop  = eop_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized bench for cmos_capture with a frame-level reference model and cycle-stamped scoreboard.
module tb_cmos_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 1;

  logic clk = 1'b0;
  logic rst;
  cmos_capture_if bus();

  cmos_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] d;
    logic        s;
    logic        e;
  } pix_t;

  pix_t exp_q[$], got_q[$];
  int   ferr_exp[$], ferr_got[$];
  int   bad_flags = 0;
  int   checks = 0, failures = 0;

  // Model state: vsync edges since reset, capture flag, current row, frame progress.
  int         edges = 0, row = 0, f_pix = 0;
  bit         in_cap = 0, f_eop = 0, use_seq = 0;
  logic [7:0] seq = 8'h00;

  always @(negedge clk) begin
    pix_t p;
    if (!rst) begin
      if (bus.dout_vld) begin
        p.t = 32'(cyc); p.d = bus.dout; p.s = bus.dout_sop; p.e = bus.dout_eop;
        got_q.push_back(p);
      end
      if (bus.frame_err) ferr_got.push_back(cyc);
      if ((bus.dout_sop || bus.dout_eop) && !bus.dout_vld) bad_flags++;
    end
  end

  task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cam_vsync = vs; bus.cam_href = hr; bus.cam_data = d;
  endtask

  task automatic vs_pulse();
    drive(1'b1, 1'b0, 8'h00);
    if (in_cap && f_pix > 0 && !f_eop) ferr_exp.push_back(cyc + 2);
    edges++;
    if (edges > SK) in_cap = 1;
    row = 0; f_pix = 0; f_eop = 0;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drive_line(input int nbytes, input int gap);
    logic [7:0] hi, b;
    pix_t p;
    int pc;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      if (use_seq) begin b = seq; seq = seq + 8'd1; end
      else b = 8'($urandom);
      drive(1'b0, 1'b1, b);
      if (i % 2 == 0) hi = b;
      else begin
        pc = i / 2;
        if (in_cap && row < V && pc < H) begin
          p.t = 32'(cyc + 2); p.d = {hi, b};
          p.s = (row == 0 && pc == 0); p.e = (row == V-1 && pc == H-1);
          exp_q.push_back(p);
          f_pix++;
          if (p.e) f_eop = 1;
        end
      end
    end
    if (in_cap && nbytes >= 2 && row < V) row++;
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
    checks++; if (bus.dout_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", bus.dout_vld); end
    checks++; if (bus.dout_sop !== 1'b0) begin failures++; $display("FAIL reset_sop got=%b exp=0", bus.dout_sop); end
    checks++; if (bus.dout_eop !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", bus.dout_eop); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
    rst = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic();
    int eb, gb, fe, fg;
    eb = exp_q.size(); gb = got_q.size(); fe = ferr_exp.size(); fg = ferr_got.size();
    vs_pulse();
    drive_line(8, 2); drive_line(8, 2);
    vs_pulse();
    use_seq = 1; seq = 8'h00;
    drive_line(8, 1); drive_line(8, 1);
    use_seq = 0;
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== 8 || exp_q.size() - eb !== 8) begin
      failures++; $display("FAIL basic_count got=%0d exp=8", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL basic_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
      end
      checks++;
      if (got_q[gb].d !== 16'h0001 || got_q[gb].s !== 1'b1) begin failures++; $display("FAIL basic_first got=%h sop=%b exp=0001 sop=1", got_q[gb].d, got_q[gb].s); end
      checks++;
      if (got_q[gb+7].d !== 16'h0E0F || got_q[gb+7].e !== 1'b1) begin failures++; $display("FAIL basic_last got=%h eop=%b exp=0e0f eop=1", got_q[gb+7].d, got_q[gb+7].e); end
    end
    checks++;
    if (ferr_got.size() - fg !== ferr_exp.size() - fe) begin failures++; $display("FAIL basic_ferr got=%0d exp=%0d", ferr_got.size() - fg, ferr_exp.size() - fe); end
  endtask

  task automatic test_odd_byte();
    int eb, gb;
    eb = exp_q.size(); gb = got_q.size();
    drive_line(9, 2); drive_line(8, 2);
    drive_line(7, 2);
    vs_pulse();
    drive_line(7, 1); drive_line(8, 1);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin
      failures++; $display("FAIL odd_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL odd_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_short_frame();
    int eb, gb, fe, fg;
    eb = exp_q.size(); gb = got_q.size(); fe = ferr_exp.size(); fg = ferr_got.size();
    drive_line(8, 2); drive_line(2, 2);
    vs_pulse();
    drive_line(8, 2); drive_line(8, 2);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin
      failures++; $display("FAIL short_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL short_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (ferr_got.size() - fg !== 1 || ferr_exp.size() - fe !== 1) begin
      failures++; $display("FAIL short_ferr_count got=%0d exp=1", ferr_got.size() - fg);
    end else begin
      checks++;
      if (ferr_got[fg] !== ferr_exp[fe]) begin failures++; $display("FAIL short_ferr_cycle got=%0d exp=%0d", ferr_got[fg], ferr_exp[fe]); end
    end
  endtask

  task automatic test_long_line();
    int eb, gb, fg;
    eb = exp_q.size(); gb = got_q.size(); fg = ferr_got.size();
    drive_line(12, 2); drive_line(12, 2); drive_line(8, 2);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== 8 || exp_q.size() - eb !== 8) begin
      failures++; $display("FAIL long_count got=%0d exp=8", got_q.size() - gb);
    end else for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL long_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (ferr_got.size() - fg !== 0) begin failures++; $display("FAIL long_ferr got=%0d exp=0", ferr_got.size() - fg); end
  endtask

  task automatic test_gaps();
    int eb, gb;
    eb = exp_q.size(); gb = got_q.size();
    drive_line(8, 3); drive_line(8, 3);
    vs_pulse();
    drive_line(8, 1); drive_line(8, 1);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin
      failures++; $display("FAIL gaps_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL gaps_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (bus.dout_vld !== 1'b0 || bus.dout !== exp_q[exp_q.size()-1].d) begin
      failures++; $display("FAIL gaps_hold got=%h vld=%b exp=%h", bus.dout, bus.dout_vld, exp_q[exp_q.size()-1].d);
    end
    vs_pulse();
  endtask

  task automatic test_random();
    int eb, gb, fe, fg, nl;
    eb = exp_q.size(); gb = got_q.size(); fe = ferr_exp.size(); fg = ferr_got.size();
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) drive_line($urandom_range(0, 13), $urandom_range(1, 3));
      vs_pulse();
    end
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== exp_q.size() - eb) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL rand_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (ferr_got.size() - fg !== ferr_exp.size() - fe) begin
      failures++; $display("FAIL rand_ferr_count got=%0d exp=%0d", ferr_got.size() - fg, ferr_exp.size() - fe);
    end else for (int i = 0; i < ferr_exp.size() - fe; i++) begin
      checks++;
      if (ferr_got[fg+i] !== ferr_exp[fe+i]) begin failures++; $display("FAIL rand_ferr%0d got=%0d exp=%0d", i, ferr_got[fg+i], ferr_exp[fe+i]); end
    end
    checks++;
    if (bad_flags !== 0) begin failures++; $display("FAIL flag_without_vld got=%0d exp=0", bad_flags); end
  endtask

  task automatic test_mid_reset();
    int eb, gb, fe, fg;
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin b = 8'($urandom); drive(1'b0, 1'b1, b); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout !== 16'h0000 || bus.dout_vld !== 1'b0 || bus.dout_sop !== 1'b0 ||
        bus.dout_eop !== 1'b0 || bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got dout=%h vld=%b exp dout=0000 vld=0", bus.dout, bus.dout_vld);
    end
    bus.cam_href = 1'b0; bus.cam_data = 8'h00;
    edges = 0; in_cap = 0; row = 0; f_pix = 0; f_eop = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    eb = exp_q.size(); gb = got_q.size(); fe = ferr_exp.size(); fg = ferr_got.size();
    vs_pulse();
    drive_line(8, 2); drive_line(8, 2);
    vs_pulse();
    drive_line(8, 2); drive_line(8, 2);
    vs_pulse();
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (got_q.size() - gb !== 8 || exp_q.size() - eb !== 8) begin
      failures++; $display("FAIL midrst_count got=%0d exp=8", got_q.size() - gb);
    end else for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL midrst_pix%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (ferr_got.size() - fg !== 0) begin failures++; $display("FAIL midrst_ferr got=%0d exp=0", ferr_got.size() - fg); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_byte();
    test_short_frame();
    test_long_line();
    test_gaps();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640: pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480: lines per frame.
REQ-003 SHALL have parameter SKIP_FRAMES, default 10: frames discarded after reset while the sensor settles.
REQ-004 SHALL have port clk, input, 1 bit: camera pixel clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cam_vsync, input, 1 bit: frame sync; a rising edge marks a frame boundary.
REQ-007 SHALL have port cam_href, input, 1 bit: line valid; high while bytes are valid.
REQ-008 SHALL have port cam_data, input, 8 bits: DVP byte stream, RGB565 high byte first.
REQ-009 SHALL have port dout, output, 16 bits: RGB565 pixel.
REQ-010 SHALL have port dout_vld, output, 1 bit: dout valid, one-cycle strobe per pixel.
REQ-011 SHALL have port dout_sop, output, 1 bit: first pixel of a frame, coincident with dout_vld.
REQ-012 SHALL have port dout_eop, output, 1 bit: last pixel of a frame, coincident with dout_vld.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame ends with the wrong pixel count.

Function
REQ-014 SHALL register cam_vsync, cam_href and cam_data once before any use, and SHALL detect the vsync rising edge on the registered copy.
REQ-015 SHALL implement the states SKIP, WAIT_VS and CAPTURE.
REQ-016 In SKIP: SHALL count vsync rising edges and SHALL move to CAPTURE on edge number SKIP_FRAMES+1. With SKIP_FRAMES=0, SHALL go to WAIT_VS instead.
REQ-017 In WAIT_VS: SHALL move to CAPTURE on the next vsync rising edge.
REQ-018 In CAPTURE: SHALL clear the column and row counters on every vsync rising edge and stay in CAPTURE.
REQ-019 Byte pairing: SHALL treat the first href-high byte as the high byte and the next as the low byte, giving pixel {hi,lo}.
REQ-020 Byte pairing: the byte toggle SHALL clear whenever href is low, and a dangling odd byte at line end SHALL be discarded.
REQ-021 Latency: SHALL raise dout_vld exactly 2 clk cycles after the low byte is present on cam_data; dout SHALL hold its value between strobes.
REQ-022 Outputs SHALL be produced only in CAPTURE; pixels arriving in SKIP or WAIT_VS SHALL be dropped.
REQ-023 Counters: the column counter SHALL run 0..H_PIXELS-1 and the row counter SHALL run 0..V_LINES-1.
REQ-024 Counters: the row counter SHALL advance on the falling edge of registered href when col>0.
REQ-025 Counters: counter widths SHALL be $clog2 of the parameter.
REQ-026 SHALL assert dout_sop with the pixel at col=0,row=0, and dout_eop with the pixel at col=H_PIXELS-1,row=V_LINES-1.
REQ-027 SHALL drop pixels beyond H_PIXELS in a line and rows beyond V_LINES with no output; the counters SHALL saturate.
REQ-028 SHALL pulse frame_err for one cycle, coincident with the vsync edge, when that edge arrives in CAPTURE after at least one pixel and before eop was issued.
REQ-029 For a short frame, SHALL emit no eop; downstream SHALL recover on the next sop.
REQ-030 Simultaneous vsync edge and pixel completion: the vsync edge SHALL win and the pixel SHALL be dropped.
REQ-031 SHALL keep dout_sop, dout_eop and frame_err low whenever dout_vld is low; frame_err excepted per REQ-028.

Reset
REQ-032 On rst: dout SHALL be 0, dout_vld, dout_sop, dout_eop and frame_err SHALL be 0, and all counters, the byte toggle and the input registers SHALL be 0.
REQ-033 On rst: the state SHALL be SKIP.
REQ-034 Reset asserted mid-frame SHALL abort immediately; after release, the full SKIP_FRAMES sequence SHALL repeat.

Structure
REQ-035 The state encoding and the default H_PIXELS/V_LINES SHALL live in the shared image package, so other pipeline stages reuse the frame size.
REQ-036 Byte-to-pixel assembly SHALL be one sub-module, dvp_byte_pair: registered 8-bit in, 16-bit out, vld.

Verification (H_PIXELS=4, V_LINES=2, SKIP_FRAMES=1)
REQ-037 Frame 1, then frame 2 with bytes 00..0F -> frame 1 gives no output; frame 2 gives 8 strobes, first dout=16'h0001 with sop, last 16'h0E0F with eop.
REQ-038 Line with 9 href bytes -> 4 pixels; 9th byte discarded; next line starts on the high byte.
REQ-039 Vsync rising edge after 5 of 8 pixels -> frame_err pulse, no eop; next frame sop at pixel 0.
REQ-040 Line with 6 pixels -> only 4 are output, and eop still lands on the correct final pixel.
REQ-041 rst pulsed mid-CAPTURE -> all outputs 0 within the same cycle; the first frame after release is skipped.
REQ-042 Low byte at cycle t -> dout_vld at t+2 exactly; check with href gaps of 0 and 3 cycles.
